// File: rtl/axi_write_slave.sv
// AXI4 write-channel responder: one burst at a time (AW -> W beats -> B), each beat
// becomes a registered SRAM write. Define AXI_WSLV_WLAST_CHK_EN to flag WLAST/AWLEN mismatches.
module axi_write_slave #(
    parameter int AWID_WIDTH   = 4,
    parameter int AWADDR_WIDTH = 10,
    parameter int WDATA_WIDTH  = 64,
    parameter int MEM_AW       = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AWID_WIDTH-1:0]     AWID,
    input  logic [AWADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [WDATA_WIDTH-1:0]    WDATA,
    input  logic [WDATA_WIDTH/8-1:0]  WSTRB,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [AWID_WIDTH-1:0]     BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    output logic                      mem_wen,
    output logic [MEM_AW-1:0]         mem_waddr,
    output logic [WDATA_WIDTH-1:0]    mem_wdata,
    output logic [WDATA_WIDTH/8-1:0]  mem_wstrb
);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                  state;
    logic [AWID_WIDTH-1:0]   id_q;
    logic [AWADDR_WIDTH-1:0] cur_addr;
    logic [7:0]              len_q;
    logic [7:0]              beat_cnt;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic                    err;
    logic                    beat_last;
    logic                    beat_err;

    // Only INCR advances; FIXED and any erroring burst keep the address where it is.
    function automatic logic [AWADDR_WIDTH-1:0] next_addr(
        input logic [AWADDR_WIDTH-1:0] addr,
        input logic [2:0]              size,
        input logic [1:0]              burst,
        input logic                    burst_err
    );
        if (burst == 2'b01 && !burst_err)
            return addr + (AWADDR_WIDTH'(1) << size);
        return addr;
    endfunction

    always_comb begin
        beat_last = (beat_cnt == len_q);
        beat_err  = err;
`ifdef AXI_WSLV_WLAST_CHK_EN
        if (WLAST != beat_last)
            beat_err = 1'b1;
`endif
    end

`ifndef AXI_WSLV_WLAST_CHK_EN
    logic unused_wlast;
    assign unused_wlast = WLAST;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            AWREADY   <= 1'b1;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BID       <= '0;
            BRESP     <= 2'b00;
            mem_wen   <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            err       <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            mem_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (AWVALID) begin
                        id_q     <= AWID;
                        cur_addr <= AWADDR;
                        len_q    <= AWLEN;
                        size_q   <= AWSIZE;
                        burst_q  <= AWBURST;
                        beat_cnt <= '0;
                        err      <= AWBURST[1] | (AWSIZE > 3'd3);
                        AWREADY  <= 1'b0;
                        WREADY   <= 1'b1;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (WVALID) begin
                        // The beat that raises err is still written; later beats are not.
                        mem_wen   <= ~err;
                        mem_waddr <= MEM_AW'(cur_addr >> 3);
                        mem_wdata <= WDATA;
                        mem_wstrb <= WSTRB;
                        cur_addr  <= next_addr(cur_addr, size_q, burst_q, err);
                        beat_cnt  <= beat_cnt + 8'd1;
                        err       <= beat_err;
                        if (beat_last) begin
                            WREADY <= 1'b0;
                            BVALID <= 1'b1;
                            BID    <= id_q;
                            BRESP  <= beat_err ? 2'b10 : 2'b00;
                            state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    AWREADY <= 1'b1;
                    WREADY  <= 1'b0;
                    BVALID  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_slave.sv
// Scoreboard bench for axi_write_slave: a burst-level model fills expected SRAM writes and
// B responses; a negedge monitor pops and compares them as the DUT presents them.
module tb_axi_write_slave;
    localparam int IDW = 4;
    localparam int AW  = 10;
    localparam int DW  = 64;
    localparam int SW  = DW / 8;
    localparam int MAW = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic [IDW-1:0] AWID;
    logic [AW-1:0]  AWADDR;
    logic [7:0]     AWLEN;
    logic [2:0]     AWSIZE;
    logic [1:0]     AWBURST;
    logic           AWVALID;
    logic           AWREADY;
    logic [DW-1:0]  WDATA;
    logic [SW-1:0]  WSTRB;
    logic           WLAST;
    logic           WVALID;
    logic           WREADY;
    logic [IDW-1:0] BID;
    logic [1:0]     BRESP;
    logic           BVALID;
    logic           BREADY;
    logic           mem_wen;
    logic [MAW-1:0] mem_waddr;
    logic [DW-1:0]  mem_wdata;
    logic [SW-1:0]  mem_wstrb;

    always #5 clk = ~clk;

    axi_write_slave #(
        .AWID_WIDTH(IDW), .AWADDR_WIDTH(AW), .WDATA_WIDTH(DW), .MEM_AW(MAW)
    ) dut (
        .clk(clk), .rst(rst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    typedef struct {
        logic [MAW-1:0] addr;
        logic [DW-1:0]  data;
        logic [SW-1:0]  strb;
    } wr_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [1:0]     resp;
    } b_t;

    wr_t exp_wr[$];
    b_t  exp_b[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops plus B-channel stability while stalled.
    wr_t            mon_wr;
    b_t             mon_b;
    logic           bstall = 1'b0;
    logic [IDW-1:0] bid_hold;
    logic [1:0]     bresp_hold;

    initial begin
        forever begin
            @(negedge clk);
            if (mem_wen === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", {1'b1, mem_waddr}, '0);
                end else begin
                    mon_wr = exp_wr.pop_front();
                    check("wr_addr", mem_waddr, mon_wr.addr);
                    check("wr_data", mem_wdata, mon_wr.data);
                    check("wr_strb", mem_wstrb, mon_wr.strb);
                end
            end
            if (bstall) begin
                check("b_stable_valid", BVALID, 1'b1);
                check("b_stable_id", BID, bid_hold);
                check("b_stable_resp", BRESP, bresp_hold);
            end
            if (BVALID === 1'b1 && BREADY === 1'b1) begin
                if (exp_b.size() == 0) begin
                    check("unexpected_b", {1'b1, BID}, '0);
                end else begin
                    mon_b = exp_b.pop_front();
                    check("b_id", BID, mon_b.id);
                    check("b_resp", BRESP, mon_b.resp);
                end
            end
            bstall     = (BVALID === 1'b1) && (BREADY === 1'b0) && (rst === 1'b0);
            bid_hold   = BID;
            bresp_hold = BRESP;
        end
    end

    // which: 0 = AW handshake, 1 = W handshake, 2 = B handshake. Called and returns at posedge+1.
    task automatic wait_hs(input int which, input string name);
        bit ok = 0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(negedge clk);
            case (which)
                0:       ok = (AWREADY === 1'b1);
                1:       ok = (WREADY === 1'b1);
                default: ok = (BVALID === 1'b1);
            endcase
            @(posedge clk);
            #1;
        end
        if (!ok) check({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_awready"}, AWREADY, 1'b1);
        check({tag, "_wready"}, WREADY, 1'b0);
        check({tag, "_b"}, {BVALID, BID, BRESP}, '0);
        check({tag, "_mem"}, {mem_wen, mem_waddr, mem_wstrb}, '0);
        check({tag, "_mem_wdata"}, mem_wdata, '0);
    endtask

    // strb_mode: <0 random, -2 one-hot by beat, else constant. bad_beat: beat carrying WLAST
    // (-1 means the proper final beat). abort: beats driven before a mid-burst reset (-1 none).
    task automatic do_burst(input int id, input int addr, input int len, input int size,
                            input int burst, input int bad_beat, input int strb_mode,
                            input bit stall, input int abort);
        logic [DW-1:0] d[$];
        logic [SW-1:0] s[$];
        bit            wl[$];
        bit            err;
        int            nbeats;
        wr_t           w;
        b_t            b;
        nbeats = (abort >= 0) ? abort : len + 1;
        for (int i = 0; i <= len; i++) begin
            d.push_back({$urandom, $urandom});
            if (strb_mode == -2)     s.push_back(SW'(1 << (i % SW)));
            else if (strb_mode < 0)  s.push_back(SW'($urandom));
            else                     s.push_back(SW'(strb_mode));
            wl.push_back((bad_beat >= 0) ? (i == bad_beat) : (i == len));
        end
        // Reference model for the whole burst.
        err = (burst >= 2) || (size > 3);
        for (int i = 0; i < nbeats; i++) begin
            if (!err) begin
                w.addr = MAW'((burst == 1 ? (addr + i * (1 << size)) % (1 << AW) : addr) / 8);
                w.data = d[i];
                w.strb = s[i];
                exp_wr.push_back(w);
            end
`ifdef AXI_WSLV_WLAST_CHK_EN
            if (wl[i] != (i == len)) err = 1;
`endif
        end
        if (abort < 0) begin
            b.id   = IDW'(id);
            b.resp = err ? 2'b10 : 2'b00;
            exp_b.push_back(b);
        end

        AWID = IDW'(id); AWADDR = AW'(addr); AWLEN = 8'(len);
        AWSIZE = 3'(size); AWBURST = 2'(burst); AWVALID = 1'b1;
        wait_hs(0, "aw");
        AWVALID = 1'b0;
        check("wready_latency", WREADY, 1'b1);
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(3) == 0) begin
                WVALID = 1'b0; WLAST = 1'b0;
                @(posedge clk);
                #1;
            end
            WDATA = d[i]; WSTRB = s[i]; WLAST = wl[i]; WVALID = 1'b1;
            wait_hs(1, "w");
        end
        WVALID = 1'b0; WLAST = 1'b0;

        if (abort >= 0) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            check_reset_vals("abort");
            BREADY = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            BREADY = 1'b0;
            return;
        end

        check("bvalid_latency", BVALID, 1'b1);
        if (stall) begin
            AWID = IDW'($urandom); AWADDR = AW'($urandom); AWLEN = 8'd0; AWVALID = 1'b1;
            repeat (5) begin
                @(negedge clk);
                check("awready_in_resp", AWREADY, 1'b0);
                @(posedge clk);
                #1;
            end
            AWVALID = 1'b0;
        end
        BREADY = 1'b1;
        wait_hs(2, "b");
        BREADY = 1'b0;
        check("awready_latency", AWREADY, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int id, addr, len, size, burst, bad, r;
        rst = 1'b1; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; WLAST = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; WDATA = '0; WSTRB = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        // WVALID in IDLE must not be accepted.
        WVALID = 1'b1;
        @(negedge clk);
        check("wready_idle", WREADY, 1'b0);
        @(posedge clk);
        #1;
        WVALID = 1'b0;

        do_burst(5, 'h010, 3, 3, 1, -1, 'hFF, 0, -1);
        do_burst(1, 'h3F8, 1, 3, 1, -1, -1, 0, -1);
        do_burst(2, 'h100, 2, 3, 2, -1, -1, 0, -1);
        do_burst(3, 'h040, 2, 3, 0, -1, -2, 0, -1);
        do_burst(4, 'h080, 3, 3, 1, 1, -1, 0, -1);
        do_burst(6, 'h200, 2, 2, 1, -1, -1, 1, -1);
        do_burst(7, 'h008, 0, 4, 1, -1, -1, 0, -1);
        do_burst(9, 'h300, 3, 1, 3, -1, -1, 0, -1);
        do_burst(10, 'h3C0, 255, 3, 1, -1, -1, 0, -1);
        do_burst(11, 'h020, 5, 3, 1, -1, -1, 0, 2);
        do_burst(12, 'h060, 1, 3, 1, -1, -1, 0, -1);

        for (int k = 0; k < 30; k++) begin
            id   = $urandom_range(15);
            addr = $urandom_range(1023);
            len  = $urandom_range(15);
            size = ($urandom_range(9) == 0) ? $urandom_range(7) : $urandom_range(3);
            r    = $urandom_range(9);
            burst = (r < 6) ? 1 : (r < 8) ? 0 : (r == 8) ? 2 : 3;
            bad  = ($urandom_range(5) == 0) ? $urandom_range(len + 1) : -1;
            do_burst(id, addr, len, size, burst, bad, -1, ($urandom_range(3) == 0), -1);
        end

        repeat (5) @(posedge clk);
        #1;
        check("writes_drained", exp_wr.size(), 0);
        check("b_drained", exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
